// File: rtl/cpu_int_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, WAIT timeout,
// default vector layout and the interrupt ID width.
package cpu_int_pkg;

    localparam int          ID_W           = 4;
    localparam int          WAIT_TIMEOUT   = 4;
    localparam logic [15:0] DEF_VEC_BASE   = 16'h0010;
    localparam logic [15:0] DEF_VEC_STRIDE = 16'h0004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ISR,
        ST_DRAIN
    } int_fsm_e;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module int_prio_enc
    import cpu_int_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req_i,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    // Scan from the top down so the lowest set index is the final assignment.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/int_ctrl.sv
// Single-level interrupt controller: edge-latched pending bits, fixed priority,
// one-cycle injection into EXE. Define INT_VECTOR_EN for per-source ISR vectors.
module int_ctrl
    import cpu_int_pkg::*;
#(
    parameter int          N_SRC    = 4,
    parameter logic [15:0] VEC_BASE = DEF_VEC_BASE
`ifdef INT_VECTOR_EN
    ,
    parameter logic [15:0] VEC_STRIDE = DEF_VEC_STRIDE
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq,
    input  logic             en_wr,
    input  logic [N_SRC-1:0] en_wdata,
    input  logic             gie,
    input  logic             stall,
    input  logic             int_state,
    input  logic             ret_exe,
    output logic             int_in,
    output logic [15:0]      int_vec,
    output logic [3:0]       int_id,
    output logic             busy,
    output logic [N_SRC-1:0] pending,
    output logic [15:0]      int_cnt
);

    int_fsm_e         state_q, state_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic [15:0]      int_cnt_q, int_cnt_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;

    logic [N_SRC-1:0] eligible;
    logic [ID_W-1:0]  win_idx;
    logic             win_any;
    logic             issue;
    logic             timeout;

    assign eligible = pending_q & en_q & {N_SRC{gie}};

    int_prio_enc #(
        .N(N_SRC)
    ) u_prio (
        .req_i(eligible),
        .idx_o(win_idx),
        .any_o(win_any)
    );

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_any && !stall && !int_state) begin
                    state_d = ST_ISSUE;
                    issue   = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (int_state) begin
                    state_d = ST_ISR;
                end else if (wait_cnt_q == 3'(WAIT_TIMEOUT - 1)) begin
                    // EXE never acknowledged: abandon and re-arm the source.
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_ISR: begin
                if (ret_exe && int_state) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign wait_cnt_d = (state_q == ST_WAIT && !int_state) ? wait_cnt_q + 3'd1 : 3'd0;
    assign en_d       = en_wr ? en_wdata : en_q;
    assign int_id_d   = issue ? win_idx : int_id_q;
    assign int_cnt_d  = issue ? int_cnt_q + 16'd1 : int_cnt_q;

    // A new edge on a bit overrides its clear in the same cycle.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
        assign pending_d[gi] = (pending_q[gi] & ~(issue && win_idx == ID_W'(gi)))
                             | (irq[gi] & ~irq_q[gi])
                             | (timeout && int_id_q == ID_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            irq_q      <= '0;
            en_q       <= '0;
            pending_q  <= '0;
            int_id_q   <= '0;
            int_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq;
            en_q       <= en_d;
            pending_q  <= pending_d;
            int_id_q   <= int_id_d;
            int_cnt_q  <= int_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign int_in  = (state_q == ST_ISSUE);
    assign busy    = (state_q != ST_IDLE);
    assign int_id  = int_id_q;
    assign pending = pending_q;
    assign int_cnt = int_cnt_q;

`ifdef INT_VECTOR_EN
    assign int_vec = VEC_BASE + 16'(int_id_q) * VEC_STRIDE;
`else
    assign int_vec = VEC_BASE;
`endif

endmodule
